// File: rtl/dmem_sized_ctrl.sv
// Sized load/store controller over a 32-bit word memory: byte/half/word access,
// alignment checking, sign/zero extension, and read-modify-write when lanes are not separately writable.
module dmem_sized_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int BYTE_LANES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR, RESP} state_t;

  state_t              state_reg;
  logic [ADDR_W-3:0]   lat_idx_reg;
  logic [3:0]          lat_be_reg;
  logic [31:0]         lat_wdata_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic                rsp_load_reg;
  logic [1:0]          rsp_off_reg;
  logic [1:0]          rsp_size_reg;
  logic                rsp_uns_reg;
  logic [31:0]         rdata_hold_reg;

  logic [ADDR_W-3:0]   req_idx;
  logic                accept;
  logic                req_err;
  logic [3:0]          req_be;
  logic [31:0]         req_wdata_al;
  logic                req_rmw;

  logic                mem_we;
  logic                mem_re;
  logic [ADDR_W-3:0]   mem_widx;
  logic [ADDR_W-3:0]   mem_ridx;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_be;
  logic [31:0]         mem_q;
  logic [31:0]         merged_word;
  logic [31:0]         shifted_word;
  logic [31:0]         load_ext;

  assign req_idx   = req_addr[ADDR_W-1:2];
  assign req_ready = rst_n && ((state_reg == IDLE) || (state_reg == RESP));
  assign accept    = req_valid && req_ready;

  // Lane mask, lane-replicated store data and alignment/size error for the incoming request.
  always_comb begin
    req_err      = 1'b0;
    req_be       = 4'hF;
    req_wdata_al = req_wdata;
    case (req_size)
      2'b00: begin
        req_be       = 4'b0001 << req_addr[1:0];
        req_wdata_al = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_al = {2{req_wdata[15:0]}};
        req_err      = req_addr[0];
      end
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  assign req_rmw = req_we && !req_err && (BYTE_LANES == 0) && (req_size != 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rsp_valid_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_load_reg   <= 1'b0;
      rsp_off_reg    <= 2'b00;
      rsp_size_reg   <= 2'b00;
      rsp_uns_reg    <= 1'b0;
      rdata_hold_reg <= '0;
      lat_idx_reg    <= '0;
      lat_be_reg     <= '0;
      lat_wdata_reg  <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (rsp_valid_reg) begin
        rdata_hold_reg <= rsp_rdata;
      end
      case (state_reg)
        IDLE, RESP: begin
          if (accept) begin
            lat_idx_reg   <= req_idx;
            lat_be_reg    <= req_be;
            lat_wdata_reg <= req_wdata_al;
            rsp_load_reg  <= !req_we && !req_err;
            rsp_off_reg   <= req_addr[1:0];
            rsp_size_reg  <= req_size;
            rsp_uns_reg   <= req_unsigned;
            if (req_rmw) begin
              state_reg <= RMW_RD;
            end else begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= req_err;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        RMW_RD: state_reg <= RMW_WR;
        RMW_WR: begin
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = lat_be_reg[gi] ? lat_wdata_reg[8*gi +: 8] : mem_q[8*gi +: 8];
    end
  endgenerate

  // The merge write is gated by rst_n so a reset landing on the write edge cannot commit a half-done store.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = req_idx;
    mem_wdata = req_wdata_al;
    mem_be    = req_be;
    if (state_reg == RMW_WR) begin
      mem_we    = rst_n;
      mem_widx  = lat_idx_reg;
      mem_wdata = merged_word;
      mem_be    = 4'hF;
    end else if (accept && req_we && !req_err && !req_rmw) begin
      mem_we = 1'b1;
    end
  end

  assign mem_re   = accept || (state_reg == RMW_RD);
  assign mem_ridx = (state_reg == RMW_RD) ? lat_idx_reg : req_idx;

  generate
    if (BYTE_LANES != 0) begin : g_lanes
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_b [DEPTH];
        logic [7:0] q_reg;
        always_ff @(posedge clk) begin
          if (mem_we && mem_be[gi]) begin
            mem_b[mem_widx] <= mem_wdata[8*gi +: 8];
          end
          if (mem_re) begin
            q_reg <= mem_b[mem_ridx];
          end
        end
        assign mem_q[8*gi +: 8] = q_reg;
      end
    end else begin : g_word
      logic [31:0] mem_w [DEPTH];
      logic [31:0] q_reg;
      always_ff @(posedge clk) begin
        if (mem_we && (&mem_be)) begin
          mem_w[mem_widx] <= mem_wdata;
        end
        if (mem_re) begin
          q_reg <= mem_w[mem_ridx];
        end
      end
      assign mem_q = q_reg;
    end
  endgenerate

  assign shifted_word = mem_q >> {rsp_off_reg, 3'b000};

  always_comb begin
    case (rsp_size_reg)
      2'b00:   load_ext = {{24{!rsp_uns_reg && shifted_word[7]}}, shifted_word[7:0]};
      2'b01:   load_ext = {{16{!rsp_uns_reg && shifted_word[15]}}, shifted_word[15:0]};
      default: load_ext = mem_q;
    endcase
  end

  // Outside a response the last delivered data is replayed from the hold register.
  always_comb begin
    rsp_rdata = rdata_hold_reg;
    if (rsp_valid_reg) begin
      rsp_rdata = rsp_load_reg ? load_ext : 32'h0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Directed and model-checked bench driving one instance per BYTE_LANES setting
// (index 0 = word-only storage, index 1 = per-byte lanes).
module tb_dmem_sized_ctrl;
  logic        clk = 1'b0;
  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [11:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [2][64];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dmem_sized_ctrl #(.ADDR_W(12), .BYTE_LANES(gi)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[gi]),
      .req_valid    (req_valid[gi]),
      .req_ready    (req_ready[gi]),
      .req_we       (req_we[gi]),
      .req_size     (req_size[gi]),
      .req_unsigned (req_unsigned[gi]),
      .req_addr     (req_addr[gi]),
      .req_wdata    (req_wdata[gi]),
      .rsp_valid    (rsp_valid[gi]),
      .rsp_rdata    (rsp_rdata[gi]),
      .rsp_err      (rsp_err[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, waits (bounded) for its response; called 1 time unit after a rising edge.
  task automatic issue(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat, output int rdy_low);
    int waitc = 0;
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wdata;
    while (!req_ready[d] && waitc < 10) begin
      @(posedge clk); #1; waitc++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    rdy_low = 0;
    while (!rsp_valid[d] && lat < 10) begin
      if (!req_ready[d]) rdy_low++;
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata[d];
    err = rsp_err[d];
    @(posedge clk); #1;
    chk($sformatf("single_pulse d%0d a%03h", d, addr), {31'b0, rsp_valid[d]}, 32'h0);
  endtask

  task automatic op(input int d, input logic we, input logic [1:0] size, input logic uns,
                    input logic [11:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic err;
    int lat, rdy_low, exp_lat;
    exp_lat = (we && !exp_err && d == 0 && size != 2'b10) ? 3 : 1;
    issue(d, we, size, uns, addr, wdata, rdata, err, lat, rdy_low);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdylow"}, rdy_low, exp_lat - 1);
    $display("d%0d %s we=%0b size=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
             d, tag, we, size, addr, wdata, rdata, err, lat);
  endtask

  // Store immediately followed by a load in the response cycle.
  task automatic b2b(input int d, input logic [1:0] st_size, input logic [11:0] st_addr,
                     input logic [31:0] st_wdata, input logic [11:0] ld_addr, input logic [31:0] exp_rdata);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_size[d] = st_size;
    req_unsigned[d] = 1'b0; req_addr[d] = st_addr; req_wdata[d] = st_wdata;
    @(posedge clk); #1;
    chk($sformatf("b2b_st_valid d%0d", d), {31'b0, rsp_valid[d]}, 32'h1);
    chk($sformatf("b2b_st_rdata d%0d", d), rsp_rdata[d], 32'h0);
    chk($sformatf("b2b_ready d%0d", d), {31'b0, req_ready[d]}, 32'h1);
    req_we[d] = 1'b0; req_size[d] = 2'b10; req_addr[d] = ld_addr;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    chk($sformatf("b2b_ld_valid d%0d", d), {31'b0, rsp_valid[d]}, 32'h1);
    chk($sformatf("b2b_ld_rdata d%0d", d), rsp_rdata[d], exp_rdata);
    @(posedge clk); #1;
    chk($sformatf("b2b_idle d%0d", d), {31'b0, rsp_valid[d]}, 32'h0);
    chk($sformatf("b2b_hold d%0d", d), rsp_rdata[d], exp_rdata);
    $display("d%0d b2b store %08h@%03h then load %03h -> %08h", d, st_wdata, st_addr, ld_addr, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_v, wd;
    logic [5:0]  off;
    logic [1:0]  sz;
    logic        we, uns, e;
    int          nb;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    #2;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid d%0d", d), {31'b0, rsp_valid[d]}, 32'h0);
      chk($sformatf("rst_err d%0d", d), {31'b0, rsp_err[d]}, 32'h0);
      chk($sformatf("rst_rdata d%0d", d), rsp_rdata[d], 32'h0);
      chk($sformatf("rst_ready d%0d", d), {31'b0, req_ready[d]}, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post_rst_ready d%0d", d), {31'b0, req_ready[d]}, 32'h1);
    end

    for (int d = 0; d < 2; d++) begin
      op(d, 1, 2'b10, 0, 12'h010, 32'h8000_00FF, 32'h0, 0, "st_w010");
      op(d, 0, 2'b00, 0, 12'h010, 32'h0, 32'hFFFF_FFFF, 0, "ld_b010s");
      op(d, 0, 2'b00, 1, 12'h010, 32'h0, 32'h0000_00FF, 0, "ld_b010u");
      op(d, 0, 2'b00, 0, 12'h013, 32'h0, 32'hFFFF_FF80, 0, "ld_b013s");
      op(d, 0, 2'b01, 0, 12'h012, 32'h0, 32'hFFFF_8000, 0, "ld_h012s");
      op(d, 0, 2'b01, 1, 12'h012, 32'h0, 32'h0000_8000, 0, "ld_h012u");
      op(d, 1, 2'b10, 0, 12'h020, 32'h1122_3344, 32'h0, 0, "st_w020");
      op(d, 1, 2'b01, 0, 12'h022, 32'h0000_BEEF, 32'h0, 0, "st_h022");
      op(d, 0, 2'b10, 0, 12'h020, 32'h0, 32'hBEEF_3344, 0, "ld_w020");
      op(d, 1, 2'b00, 0, 12'h021, 32'h0000_0077, 32'h0, 0, "st_b021");
      op(d, 0, 2'b10, 0, 12'h020, 32'h0, 32'hBEEF_7744, 0, "ld_w020b");
      op(d, 0, 2'b01, 0, 12'h001, 32'h0, 32'h0, 1, "ld_h001_err");
      op(d, 1, 2'b10, 0, 12'h004, 32'h1234_5678, 32'h0, 0, "st_w004");
      op(d, 1, 2'b10, 0, 12'h006, 32'hDEAD_BEEF, 32'h0, 1, "st_w006_err");
      op(d, 1, 2'b01, 0, 12'h005, 32'h0000_CAFE, 32'h0, 1, "st_h005_err");
      op(d, 0, 2'b11, 0, 12'h004, 32'h0, 32'h0, 1, "ld_sz3_err");
      op(d, 0, 2'b10, 0, 12'h004, 32'h0, 32'h1234_5678, 0, "ld_w004");
      op(d, 1, 2'b10, 0, 12'h030, 32'h0, 32'h0, 0, "clr_w030");
    end

    b2b(1, 2'b00, 12'h030, 32'h0000_005A, 12'h030, 32'h0000_005A);
    b2b(0, 2'b10, 12'h034, 32'hCAFE_F00D, 12'h034, 32'hCAFE_F00D);

    op(0, 1, 2'b10, 0, 12'h040, 32'h0, 32'h0, 0, "clr_w040");
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b00;
    req_addr[0] = 12'h040; req_wdata[0] = 32'h0000_00AA;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("rmw_rd_ready", {31'b0, req_ready[0]}, 32'h0);
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    #1;
    chk("abort_valid", {31'b0, rsp_valid[0]}, 32'h0);
    chk("abort_ready", {31'b0, req_ready[0]}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_rsp", {31'b0, rsp_valid[0]}, 32'h0);
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    $display("d0 reset during RMW_WR of byte store 0xAA@040");
    op(0, 0, 2'b10, 0, 12'h040, 32'h0, 32'h0, 0, "ld_w040_abort");

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        op(d, 1, 2'b10, 0, 12'h100 + 12'(w * 4), 32'h0, 32'h0, 0, "rnd_init");
        for (int b = 0; b < 4; b++) mdl[d][w * 4 + b] = 8'h00;
      end
      for (int n = 0; n < 40; n++) begin
        sz  = 2'($urandom_range(0, 3));
        off = 6'($urandom_range(0, 63));
        we  = 1'($urandom_range(0, 1));
        uns = 1'($urandom_range(0, 1));
        wd  = $urandom;
        e   = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off[1:0] != 2'b00);
        nb  = 1 << sz;
        exp_v = 32'h0;
        if (!e && we) begin
          for (int i = 0; i < nb; i++) mdl[d][int'(off) + i] = wd[8*i +: 8];
        end else if (!e) begin
          for (int i = 0; i < nb; i++) exp_v = exp_v | (32'(mdl[d][int'(off) + i]) << (8 * i));
          if (!uns && nb == 1 && exp_v[7]) exp_v = exp_v | 32'hFFFF_FF00;
          if (!uns && nb == 2 && exp_v[15]) exp_v = exp_v | 32'hFFFF_0000;
        end
        op(d, we, sz, uns, 12'h100 + {6'b0, off}, wd, exp_v, e, $sformatf("rnd%0d", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
